instruction_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_skid_fifo.sv | 56 +++++
 rtl/instruction_fetch.sv | 85 ++++++++
 tb/tb_instruction_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: default geometry and the fetch-to-decode beat layout.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_LAST_ADDR  = 63;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] instr;
        logic [DEF_ADDR_WIDTH-1:0] pc;
    } fetch_beat_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry in-order buffer between the memory response and decode; flush beats push.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter type beat_t = fetch_beat_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  beat_t      beat,
    input  logic       pop,
    input  logic       flush,
    output beat_t      head,
    output logic [1:0] count
);

    beat_t      e0_q;
    beat_t      e1_q;
    logic [1:0] count_q;

    assign head  = e0_q;
    assign count = count_q;

    // e0 is always the head; e1 only holds the second entry when count is 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) e0_q <= beat;
                    else                 e1_q <= beat;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    e0_q    <= e1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_q <= beat;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= beat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads memory every cycle and hands words with
// their PC to decode over valid/ready, discarding stale fetches on a redirect.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned LAST_ADDR  = DEF_LAST_ADDR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    input  logic [DATA_WIDTH-1:0] instruction_data,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  out_ready
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } beat_t;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q;
    logic                  inflight_q;
    logic                  issue;
    logic                  pop;
    logic [2:0]            occupancy;
    logic [1:0]            count;
    beat_t                 push_beat;
    beat_t                 head;

    assign instruction_address = pc_q;
    assign out_valid           = (count != 2'd0);
    assign out_instr           = head.instr;
    assign out_pc              = head.pc;
    assign push_beat.instr     = instruction_data;
    assign push_beat.pc        = inflight_pc_q;

    // Issue only when the response is guaranteed a FIFO slot after this cycle's pop.
    always_comb begin
        pop       = out_valid & out_ready;
        occupancy = 3'(count) + 3'(inflight_q) - 3'(pop);
        issue     = !branch_valid && (occupancy < 3'd2);
        pc_d      = pc_q;
        if (branch_valid) begin
            pc_d = branch_target;
        end else if (issue) begin
            pc_d = (pc_q == ADDR_WIDTH'(LAST_ADDR)) ? '0 : pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= ADDR_WIDTH'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= pc_q;
        end
    end

    // A branch flushes the buffer, which also drops the in-flight response.
    fetch_skid_fifo #(
        .beat_t (beat_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .beat  (push_beat),
        .pop   (pop),
        .flush (branch_valid),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with a synchronous-read memory model.
module tb_instruction_fetch;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] instr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] instruction_address;
    logic [7:0] instruction_data;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       out_valid;
    logic [7:0] out_instr;
    logic [7:0] out_pc;
    logic       out_ready;

    exp_t q[$];
    logic mon_en = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .RESET_PC   (0),
        .LAST_ADDR  (63)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .instruction_address (instruction_address),
        .instruction_data    (instruction_data),
        .branch_valid        (branch_valid),
        .branch_target       (branch_target),
        .out_valid           (out_valid),
        .out_instr           (out_instr),
        .out_pc              (out_pc),
        .out_ready           (out_ready)
    );

    // instruction_mem[i] = i ^ 8'hA5, synchronous read
    always @(posedge clk) instruction_data <= instruction_address ^ 8'hA5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) begin
            exp_t e;
            e.pc    = 8'(p);
            e.instr = 8'(p) ^ 8'hA5;
            q.push_back(e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges, checks reset outputs, releases just after an edge (cycle 0).
    task automatic do_reset;
        mon_en       = 1'b0;
        rst_n        = 1'b0;
        branch_valid = 1'b0;
        out_ready    = 1'b1;
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_pc", 32'(out_pc), 0);
        check("rst_instr", 32'(out_instr), 0);
        check("rst_addr", 32'(instruction_address), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    exp_t m_e;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("addr_range", 32'(instruction_address <= 8'd63), 1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got pc %0h want no beat", out_pc);
                end else begin
                    m_e = q.pop_front();
                    check("beat_pc", 32'(out_pc), 32'(m_e.pc));
                    check("beat_instr", 32'(out_instr), 32'(m_e.instr));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        out_ready     = 1'b1;
        branch_valid  = 1'b0;
        branch_target = 8'h00;

        // Free run from reset, across the wrap at 63
        do_reset();
        push_exp(0, 63);
        push_exp(0, 3);
        check("s1_valid_c0", 32'(out_valid), 0);
        tick();
        check("s1_valid_c1", 32'(out_valid), 0);
        tick();
        check("s1_valid_c2", 32'(out_valid), 1);
        check("s1_first_pc", 32'(out_pc), 0);
        check("s1_first_instr", 32'(out_instr), 32'h A5);
        for (int i = 0; i < 67; i++) begin
            tick();
            check("s1_no_gap", 32'(out_valid), 1);
            if (i == 62) begin
                check("s2_last_pc", 32'(out_pc), 63);
                check("s2_last_instr", 32'(out_instr), 32'h9A);
            end
            if (i == 63) begin
                check("s2_wrap_pc", 32'(out_pc), 0);
                check("s2_wrap_instr", 32'(out_instr), 32'hA5);
            end
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("s1_drained", 32'(q.size()), 0);

        // Stall cycles 3..7
        do_reset();
        push_exp(0, 11);
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (2) tick();
        check("s3_addr_frozen_a", 32'(instruction_address), 3);
        check("s3_head_pc_a", 32'(out_pc), 1);
        check("s3_valid", 32'(out_valid), 1);
        repeat (2) tick();
        check("s3_addr_frozen_b", 32'(instruction_address), 3);
        check("s3_head_pc_b", 32'(out_pc), 1);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            check("s3_no_gap", 32'(out_valid), 1);
            tick();
        end
        mon_en = 1'b0;
        check("s3_drained", 32'(q.size()), 0);

        // Branch to 0x20 with the buffer and fetch pipe occupied
        do_reset();
        push_exp(0, 0);
        push_exp(32'h20, 32'h27);
        repeat (3) tick();
        out_ready     = 1'b0;
        branch_valid  = 1'b1;
        branch_target = 8'h20;
        tick();
        branch_valid = 1'b0;
        out_ready    = 1'b1;
        check("s4_addr_b1", 32'(instruction_address), 32'h20);
        check("s4_valid_b1", 32'(out_valid), 0);
        tick();
        check("s4_valid_b2", 32'(out_valid), 0);
        tick();
        check("s4_valid_b3", 32'(out_valid), 1);
        check("s4_pc_b3", 32'(out_pc), 32'h20);
        check("s4_instr_b3", 32'(out_instr), 32'h85);
        repeat (8) tick();
        mon_en = 1'b0;
        check("s4_drained", 32'(q.size()), 0);

        // Branch with a pop, then a second branch one cycle later
        do_reset();
        push_exp(0, 1);
        push_exp(32'h10, 32'h13);
        repeat (3) tick();
        check("s5_pop_valid", 32'(out_valid), 1);
        check("s5_pop_pc", 32'(out_pc), 1);
        branch_valid  = 1'b1;
        branch_target = 8'h30;
        tick();
        branch_target = 8'h10;
        check("s5_addr_first", 32'(instruction_address), 32'h30);
        check("s5_valid_c4", 32'(out_valid), 0);
        tick();
        branch_valid = 1'b0;
        check("s5_addr_second", 32'(instruction_address), 32'h10);
        check("s5_valid_c5", 32'(out_valid), 0);
        tick();
        check("s5_valid_c6", 32'(out_valid), 0);
        tick();
        check("s5_valid_c7", 32'(out_valid), 1);
        check("s5_pc_c7", 32'(out_pc), 32'h10);
        check("s5_instr_c7", 32'(out_instr), 32'hB5);
        repeat (4) tick();
        mon_en = 1'b0;
        check("s5_drained", 32'(q.size()), 0);

        // Asynchronous reset during a stall, then restart
        do_reset();
        push_exp(0, 0);
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        mon_en = 1'b0;
        check("s6_pre_drained", 32'(q.size()), 0);
        check("s6_pre_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_valid", 32'(out_valid), 0);
        check("s6_async_pc", 32'(out_pc), 0);
        check("s6_async_instr", 32'(out_instr), 0);
        check("s6_async_addr", 32'(instruction_address), 0);
        do_reset();
        push_exp(0, 5);
        tick();
        tick();
        check("s6_restart_valid", 32'(out_valid), 1);
        check("s6_restart_instr", 32'(out_instr), 32'hA5);
        repeat (6) tick();
        mon_en = 1'b0;
        check("s6_drained", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
